// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end; drives pc_o, captures instr_i and buffers {pc, instr} for decode.
// Optional TARTARUGA_FETCH_MISALIGN_EN: a misaligned redirect target yields one flagged NOP entry, then halts.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FBUF_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   output logic [31:0] pc_o,
   input  logic [31:0] instr_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        halt_i,
   output logic        fetch_valid_o,
   input  logic        fetch_ready_i,
   output logic [31:0] fetch_pc_o,
   output logic [31:0] fetch_instr_o,
   output logic        fetch_misaligned_o
);
   localparam int unsigned PW = $clog2(FBUF_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FBUF_DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t         state_q, state_d;
   logic [31:0]    pc_q;
   logic [31:0]    redirect_target;
   logic [31:0]    push_instr;
   logic           push_misaligned;
   logic [CW-1:0]  count_q;
   logic [PW-1:0]  rd_ptr, wr_ptr;
   logic           push, pop, not_empty;
   logic [31:0]    buf_pc    [FBUF_DEPTH];
   logic [31:0]    buf_instr [FBUF_DEPTH];

`ifdef TARTARUGA_FETCH_MISALIGN_EN
   logic           buf_mis   [FBUF_DEPTH];

   assign redirect_target = redirect_pc_i;
   assign push_misaligned = (pc_q[1:0] != 2'b00);
   assign push_instr      = push_misaligned ? NOP : instr_i;
`else
   assign redirect_target = redirect_pc_i & ~32'h3;
   assign push_misaligned = 1'b0;
   assign push_instr      = instr_i;
`endif

   assign pc_o          = pc_q;
   assign not_empty     = (count_q != '0);
   assign pop           = not_empty & fetch_ready_i;
   assign fetch_valid_o = not_empty;
   assign fetch_pc_o    = not_empty ? buf_pc[rd_ptr]    : '0;
   assign fetch_instr_o = not_empty ? buf_instr[rd_ptr] : '0;

`ifdef TARTARUGA_FETCH_MISALIGN_EN
   assign fetch_misaligned_o = not_empty & buf_mis[rd_ptr];
`else
   assign fetch_misaligned_o = 1'b0;
`endif

   always_comb begin
      push    = 1'b0;
      state_d = state_q;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (halt_i) begin
               state_d = HALT;
            end else begin
               push = (count_q < DEPTH_C) | pop;
               if (push && push_misaligned) state_d = HALT;
            end
         end
         HALT: state_d = HALT;
         default: state_d = BOOT;
      endcase
      // Redirect overrides everything: no push, flush, resume fetching.
      if (redirect_valid_i) begin
         push    = 1'b0;
         state_d = RUN;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         count_q <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
      end else begin
         state_q <= state_d;
         if (redirect_valid_i) begin
            pc_q    <= redirect_target;
            count_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
         end else begin
            if (push) begin
               pc_q   <= pc_q + 32'd4;
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // Storage needs no reset: the head mux is gated by the empty flag.
   always_ff @(posedge clk_i) begin
      if (push) begin
         buf_pc[wr_ptr]    <= pc_q;
         buf_instr[wr_ptr] <= push_instr;
`ifdef TARTARUGA_FETCH_MISALIGN_EN
         buf_mis[wr_ptr]   <= push_misaligned;
`endif
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: hand-derived vector table plus a randomized run against a queue model.
module tb_fetch_stage;
   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk, rstn;
   logic [31:0] pc_o, instr_i, redirect_pc;
   logic        redirect_valid, halt, fetch_valid, fetch_ready, fetch_mis;
   logic [31:0] fetch_pc, fetch_instr;

   int tests = 0;
   int fails = 0;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0000_10B7 : (a ^ 32'hC3C3_0013);
   endfunction

   assign instr_i = imem(pc_o);

   fetch_stage #(.RESET_PC(RPC), .FBUF_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rstn_i(rstn), .pc_o(pc_o), .instr_i(instr_i),
      .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc), .halt_i(halt),
      .fetch_valid_o(fetch_valid), .fetch_ready_i(fetch_ready), .fetch_pc_o(fetch_pc),
      .fetch_instr_o(fetch_instr), .fetch_misaligned_o(fetch_mis)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          rst;
      bit          rdy;
      bit          rd;
      logic [31:0] rpc;
      bit          hl;
      bit          ev;
      logic [31:0] epc;
      logic [31:0] einstr;
      bit          emis;
      logic [31:0] epco;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit rst, input bit rdy, input bit rd, input logic [31:0] r, input bit hl,
                      input bit ev, input logic [31:0] epc, input logic [31:0] epco, input bit emis);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rd = rd; v.rpc = r; v.hl = hl; v.ev = ev;
      v.epc    = ev ? epc : 32'h0;
      v.einstr = !ev ? 32'h0 : (emis ? 32'h0000_0013 : imem(epc));
      v.emis   = ev & emis;
      v.epco   = epco;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit rdy, input bit rd, input logic [31:0] r, input bit hl);
      fetch_ready    = rdy;
      redirect_valid = rd;
      redirect_pc    = r;
      halt           = hl;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("rst valid", {31'h0, fetch_valid}, 32'h0);
      chk("rst pc_o", pc_o, RPC);
      chk("rst head pc", fetch_pc, 32'h0);
      chk("rst head instr", fetch_instr, 32'h0);
      chk("rst mis", {31'h0, fetch_mis}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Reference model: pending entries as queues, plus whether fetching is active.
   logic [31:0] m_pc;
   bit          m_boot, m_fetching;
   logic [31:0] q_pc[$];
   logic [31:0] q_instr[$];
   bit          q_mis[$];

   task automatic model_step(input bit rdy, input bit rd, input logic [31:0] r, input bit hl);
      bit mis;
      if (rd) begin
         q_pc.delete(); q_instr.delete(); q_mis.delete();
`ifdef TARTARUGA_FETCH_MISALIGN_EN
         m_pc = r;
`else
         m_pc = {r[31:2], 2'b00};
`endif
         m_boot = 0;
         m_fetching = 1;
      end else begin
         if (rdy && q_pc.size() > 0) begin
            void'(q_pc.pop_front()); void'(q_instr.pop_front()); void'(q_mis.pop_front());
         end
         if (m_boot) begin
            m_boot = 0;
            m_fetching = 1;
         end else if (m_fetching && hl) begin
            m_fetching = 0;
         end else if (m_fetching && q_pc.size() < DEPTH) begin
`ifdef TARTARUGA_FETCH_MISALIGN_EN
            mis = (m_pc[1:0] != 2'b00);
`else
            mis = 0;
`endif
            q_pc.push_back(m_pc);
            q_instr.push_back(mis ? 32'h0000_0013 : imem(m_pc));
            q_mis.push_back(mis);
            m_pc = m_pc + 32'd4;
            if (mis) m_fetching = 0;
         end
      end
   endtask

   initial begin
      logic [31:0] mp;
      logic [31:0] mo;
      bit          f;
      bit          rdy, rd, hl;
      logic [31:0] r;
      rstn = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0);

`ifdef TARTARUGA_FETCH_MISALIGN_EN
      f = 1;
`else
      f = 0;
`endif
      // rst, rdy, redirect, target, halt | valid, head pc, pc_o, misaligned
      add(1,1,0,0,0, 0,0,0,0);  add(0,1,0,0,0, 0,0,0,0);
      add(0,1,0,0,0, 1,0,4,0);  add(0,1,0,0,0, 1,4,8,0);
      add(0,1,0,0,0, 1,8,12,0); add(0,1,0,0,0, 1,12,16,0);

      add(1,0,0,0,0, 0,0,0,0);  add(0,0,0,0,0, 0,0,0,0);
      add(0,0,0,0,0, 1,0,4,0);  add(0,0,0,0,0, 1,0,8,0);
      add(0,0,0,0,0, 1,0,8,0);  add(0,1,0,0,0, 1,0,8,0);
      add(0,1,0,0,0, 1,4,12,0); add(0,1,0,0,0, 1,8,16,0);
      add(0,1,0,0,0, 1,12,20,0);

      add(1,0,0,0,0, 0,0,0,0);  add(0,0,0,0,0, 0,0,0,0);
      add(0,0,0,0,0, 1,0,4,0);  add(0,0,0,0,0, 1,0,8,0);
      add(0,1,1,32'h100,0, 1,0,8,0);
      add(0,1,0,0,0, 0,0,32'h100,0);
      add(0,1,0,0,0, 1,32'h100,32'h104,0);
      add(0,1,0,0,0, 1,32'h104,32'h108,0);

      add(1,0,0,0,0, 0,0,0,0);  add(0,0,0,0,0, 0,0,0,0);
      add(0,0,0,0,1, 1,0,4,0);  add(0,0,0,0,0, 1,0,4,0);
      add(0,1,0,0,0, 1,0,4,0);  add(0,1,0,0,0, 0,0,4,0);
      add(0,1,1,32'h40,0, 0,0,4,0);
      add(0,1,0,0,0, 0,0,32'h40,0);
      add(0,1,0,0,0, 1,32'h40,32'h44,0);
      add(0,1,0,0,0, 1,32'h44,32'h48,0);

      add(1,1,0,0,0, 0,0,0,0);
      add(0,1,1,32'hFFFF_FFF8,0, 0,0,0,0);
      add(0,1,0,0,0, 0,0,32'hFFFF_FFF8,0);
      add(0,1,0,0,0, 1,32'hFFFF_FFF8,32'hFFFF_FFFC,0);
      add(0,1,0,0,0, 1,32'hFFFF_FFFC,32'h0,0);
      add(0,1,0,0,0, 1,32'h0,32'h4,0);

      add(1,1,0,0,0, 0,0,0,0);
      add(0,1,1,32'h102,0, 0,0,0,0);
      if (f) begin
         add(0,1,0,0,0, 0,0,32'h102,0);
         add(0,1,0,0,0, 1,32'h102,32'h106,1);
         add(0,1,0,0,0, 0,0,32'h106,0);
         add(0,1,0,0,0, 0,0,32'h106,0);
      end else begin
         add(0,1,0,0,0, 0,0,32'h100,0);
         add(0,1,0,0,0, 1,32'h100,32'h104,0);
         add(0,1,0,0,0, 1,32'h104,32'h108,0);
         add(0,1,0,0,0, 1,32'h108,32'h10C,0);
      end

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         else @(negedge clk);
         drive(tbl[i].rdy, tbl[i].rd, tbl[i].rpc, tbl[i].hl);
         #1;
         chk($sformatf("row%0d valid", i), {31'h0, fetch_valid}, {31'h0, tbl[i].ev});
         chk($sformatf("row%0d head pc", i), fetch_pc, tbl[i].epc);
         chk($sformatf("row%0d head instr", i), fetch_instr, tbl[i].einstr);
         chk($sformatf("row%0d mis", i), {31'h0, fetch_mis}, {31'h0, tbl[i].emis});
         chk($sformatf("row%0d pc_o", i), pc_o, tbl[i].epco);
         @(posedge clk);
      end

      do_reset();
      m_pc = RPC; m_boot = 1; m_fetching = 0;
      q_pc.delete(); q_instr.delete(); q_mis.delete();
      for (int n = 0; n < 3000; n++) begin
         rdy = ($urandom_range(0, 3) != 0);
         rd  = ($urandom_range(0, 15) == 0);
         hl  = ($urandom_range(0, 19) == 0);
         r   = $urandom;
         if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
         drive(rdy, rd, r, hl);
         #1;
         mp = (q_pc.size() > 0) ? q_pc[0] : 32'h0;
         mo = (q_pc.size() > 0) ? q_instr[0] : 32'h0;
         chk($sformatf("rnd%0d valid", n), {31'h0, fetch_valid}, {31'h0, q_pc.size() > 0});
         chk($sformatf("rnd%0d head pc", n), fetch_pc, mp);
         chk($sformatf("rnd%0d head instr", n), fetch_instr, mo);
         chk($sformatf("rnd%0d mis", n), {31'h0, fetch_mis},
             {31'h0, (q_pc.size() > 0) ? q_mis[0] : 1'b0});
         chk($sformatf("rnd%0d pc_o", n), pc_o, m_pc);
         @(posedge clk);
         model_step(rdy, rd, r, hl);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
